// File: rtl/rvfpm_issue_queue_pkg.sv
// Shared FPU issue-queue types: per-entry lifecycle state
// and the entry record seen by the execute back-end.
package pa_rvfpm;

  localparam int unsigned IQ_X_NUM_RS   = 3;
  localparam int unsigned IQ_XLEN       = 32;
  localparam int unsigned IQ_X_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    IQ_FREE,
    IQ_SPEC,
    IQ_COMMITTED,
    IQ_KILLED
  } iq_state_e;

  typedef struct packed {
    iq_state_e                                state;
    logic [31:0]                              instr;
    logic [IQ_X_ID_WIDTH-1:0]                 id;
    logic [IQ_X_NUM_RS-1:0][IQ_XLEN-1:0]      rs;
  } iq_entry_t;

  function automatic iq_state_e iq_resolve(input logic kill);
    return kill ? IQ_KILLED : IQ_COMMITTED;
  endfunction

endpackage

// File: rtl/rvfpm_issue_queue.sv
// In-order speculative issue queue between XIF issue/commit
// and the FPU back-end; only committed entries are released.
module rvfpm_issue_queue
  import pa_rvfpm::*;
#(
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned X_NUM_RS   = 3,
  parameter  int unsigned XLEN       = 32,
  parameter  int unsigned X_ID_WIDTH = 4,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned CW         = $clog2(DEPTH + 1),
  localparam int unsigned RSW        = X_NUM_RS * XLEN
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_accept,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [RSW-1:0]        issue_rs,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [31:0]           exec_instr,
  output logic [X_ID_WIDTH-1:0] exec_id,
  output logic [RSW-1:0]        exec_rs,
  output logic [CW-1:0]         count
);

  iq_state_e             state_q [DEPTH];
  iq_state_e             state_d [DEPTH];
  logic [31:0]           instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [RSW-1:0]        rs_q    [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] wr;
  logic [DEPTH-1:0] dup;
  logic             enq, deq, drop, leave;
  logic             enq_hit;
  iq_state_e        head_st;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue_ready = count_q < CW'(DEPTH);
  assign enq         = issue_valid & issue_accept & issue_ready;
  assign enq_hit     = commit_valid & (commit_id == issue_id);
  assign head_st     = state_q[head_q];
  assign exec_valid  = head_st == IQ_COMMITTED;
  assign drop        = head_st == IQ_KILLED;
  assign deq         = exec_valid & exec_ready;
  assign leave       = deq | drop;
  assign count       = count_q;

  assign exec_instr = exec_valid ? instr_q[head_q] : '0;
  assign exec_id    = exec_valid ? id_q[head_q]    : '0;
  assign exec_rs    = exec_valid ? rs_q[head_q]    : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (leave) head_d = ptr_inc(head_q);
      if (enq)   tail_d = ptr_inc(tail_q);
      count_d = count_q + CW'(enq) - CW'(leave);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic      hit;
    logic      at_head;
    iq_state_e st_d;

    assign at_head = head_q == PW'(i);
    assign wr[i]   = enq & (tail_q == PW'(i));
    assign hit     = commit_valid & (state_q[i] == IQ_SPEC)
                   & (commit_id == id_q[i]);
    // the leaving head is no longer in flight, so its id may be reused
    assign dup[i]  = (state_q[i] != IQ_FREE) & (id_q[i] == issue_id)
                   & ~(leave & at_head);

    always_comb begin
      st_d = state_q[i];
      if (flush)
        st_d = IQ_FREE;
      else if (wr[i])
        st_d = enq_hit ? iq_resolve(commit_kill) : IQ_SPEC;
      else if (hit)
        st_d = iq_resolve(commit_kill);
      else if (leave && at_head)
        st_d = IQ_FREE;
    end

    assign state_d[i] = st_d;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= IQ_FREE;
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        if (wr[i] && !flush) begin
          instr_q[i] <= issue_instr;
          id_q[i]    <= issue_id;
          rs_q[i]    <= issue_rs;
        end
      end
    end
  end

  a_no_dup_id: assert property (
    @(posedge ck) disable iff (!rst)
    (enq && !flush) |-> (dup == '0)
  );

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Bench for rvfpm_issue_queue: directed table at DEPTH=4,
// randomized run against a queue model at DEPTH=3.
module tb_rvfpm_issue_queue;

  logic        ck = 1'b0;
  logic        rst, flush, sel3;
  logic        issue_valid, issue_accept;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [95:0] issue_rs;
  logic        commit_valid, commit_kill, exec_ready;
  logic [3:0]  commit_id;

  logic        rdy4, ev4, rdy3, ev3;
  logic [31:0] instr4, instr3;
  logic [3:0]  id4, id3;
  logic [95:0] rs4, rs3;
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ck = ~ck;

  rvfpm_issue_queue #(.DEPTH(4)) u4 (
    .ck(ck), .rst(rst), .flush(flush),
    .issue_valid(issue_valid & ~sel3), .issue_accept(issue_accept),
    .issue_ready(rdy4), .issue_instr(issue_instr), .issue_id(issue_id),
    .issue_rs(issue_rs), .commit_valid(commit_valid & ~sel3),
    .commit_id(commit_id), .commit_kill(commit_kill),
    .exec_valid(ev4), .exec_ready(exec_ready), .exec_instr(instr4),
    .exec_id(id4), .exec_rs(rs4), .count(cnt4)
  );

  rvfpm_issue_queue #(.DEPTH(3)) u3 (
    .ck(ck), .rst(rst), .flush(flush),
    .issue_valid(issue_valid & sel3), .issue_accept(issue_accept),
    .issue_ready(rdy3), .issue_instr(issue_instr), .issue_id(issue_id),
    .issue_rs(issue_rs), .commit_valid(commit_valid & sel3),
    .commit_id(commit_id), .commit_kill(commit_kill),
    .exec_valid(ev3), .exec_ready(exec_ready), .exec_instr(instr3),
    .exec_id(id3), .exec_rs(rs3), .count(cnt3)
  );

  function automatic logic [31:0] mk_instr(input logic [3:0] id);
    return {20'hABCDE, 8'h53, id};
  endfunction

  function automatic logic [95:0] mk_rs(input logic [3:0] id);
    return {28'h3000_000, id, 28'h2000_000, id, 28'h1000_000, id};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic iv, input logic acc,
                       input logic [3:0] id, input logic cv,
                       input logic [3:0] cid, input logic kill,
                       input logic er);
    issue_valid  = iv;
    issue_accept = acc;
    issue_id     = id;
    issue_instr  = mk_instr(id);
    issue_rs     = mk_rs(id);
    commit_valid = cv;
    commit_id    = cid;
    commit_kill  = kill;
    exec_ready   = er;
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst   = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge ck);
    rst = 1'b1;
  endtask

  typedef struct {
    logic       iv, acc;
    logic [3:0] id;
    logic       cv;
    logic [3:0] cid;
    logic       kill, er;
    logic       ev;
    logic [3:0] eid;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic acc, input logic [3:0] id,
                     input logic cv, input logic [3:0] cid,
                     input logic kill, input logic er, input logic ev,
                     input logic [3:0] eid, input logic [2:0] cnt,
                     input logic rdy);
    vec_t v;
    v.iv = iv; v.acc = acc; v.id = id; v.cv = cv; v.cid = cid;
    v.kill = kill; v.er = er; v.ev = ev; v.eid = eid;
    v.cnt = cnt; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [3:0] id;
    int         st;
  } m_t;

  m_t mq[$];

  initial begin
    sel3 = 1'b0;
    rst  = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    //    iv acc id cv cid k er | ev eid cnt rdy
    add(1, 1, 1, 0, 0, 0, 1,   0, 0, 1, 1);
    add(1, 1, 2, 0, 0, 0, 1,   0, 0, 2, 1);
    add(0, 0, 0, 1, 2, 0, 1,   0, 0, 2, 1);
    add(0, 0, 0, 1, 1, 0, 1,   1, 1, 2, 1);
    add(0, 0, 0, 0, 0, 0, 1,   1, 2, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 1, 3, 1, 3, 0, 1,   1, 3, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1,   0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 0, 1,   0, 0, 2, 1);
    add(1, 1, 2, 0, 0, 0, 1,   0, 0, 3, 1);
    add(1, 1, 3, 0, 0, 0, 1,   0, 0, 4, 0);
    add(1, 1, 9, 1, 0, 1, 1,   0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 3, 1);
    add(0, 0, 0, 1, 1, 1, 1,   0, 0, 3, 1);
    add(0, 0, 0, 1, 2, 1, 1,   0, 0, 2, 1);
    add(0, 0, 0, 1, 3, 1, 1,   0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 0, 5, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 0, 0, 1, 6, 0, 1,   0, 0, 0, 1);
    add(1, 1, 6, 0, 0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0, 1, 6, 0, 0,   1, 6, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);

    // async reset with three entries queued, head committed
    do_reset();
    #1;
    chk("rst_cnt", cnt4, 0);
    chk("rst_ev", ev4, 0);
    chk("rst_rdy", rdy4, 1);
    chk("rst_id", id4, 0);
    chk("rst_rs", rs4, 0);
    @(negedge ck) drive(1, 1, 1, 0, 0, 0, 0);
    @(negedge ck) drive(1, 1, 2, 1, 1, 0, 0);
    @(negedge ck) drive(1, 1, 3, 0, 0, 0, 0);
    @(negedge ck) drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", cnt4, 3);
    chk("pre_rst_ev", ev4, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", cnt4, 0);
    chk("async_ev", ev4, 0);
    chk("async_rdy", rdy4, 1);
    @(negedge ck) rst = 1'b1;

    foreach (tbl[k]) begin
      @(negedge ck);
      drive(tbl[k].iv, tbl[k].acc, tbl[k].id, tbl[k].cv,
            tbl[k].cid, tbl[k].kill, tbl[k].er);
      @(posedge ck);
      #1;
      chk($sformatf("v%0d_ev", k), ev4, tbl[k].ev);
      chk($sformatf("v%0d_cnt", k), cnt4, tbl[k].cnt);
      chk($sformatf("v%0d_rdy", k), rdy4, tbl[k].rdy);
      if (tbl[k].ev) begin
        chk($sformatf("v%0d_id", k), id4, tbl[k].eid);
        chk($sformatf("v%0d_instr", k), instr4, mk_instr(tbl[k].eid));
        chk($sformatf("v%0d_rs", k), rs4, mk_rs(tbl[k].eid));
      end
    end

    // committed head held for 5 cycles
    @(negedge ck) drive(1, 1, 7, 1, 7, 0, 0);
    @(posedge ck);
    #1 chk("hold_ev0", ev4, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge ck) drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge ck);
      #1;
      chk($sformatf("hold%0d_ev", c), ev4, 1);
      chk($sformatf("hold%0d_id", c), id4, 7);
      chk($sformatf("hold%0d_rs", c), rs4, mk_rs(4'd7));
      chk($sformatf("hold%0d_cnt", c), cnt4, 1);
    end
    @(negedge ck) drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge ck);
    #1;
    chk("hold_rel_ev", ev4, 0);
    chk("hold_rel_cnt", cnt4, 0);

    // flush beats a same-cycle issue
    @(negedge ck) drive(1, 1, 4, 1, 4, 0, 0);
    @(negedge ck) drive(1, 1, 5, 0, 0, 0, 0);
    @(negedge ck);
    drive(1, 1, 8, 1, 5, 0, 0);
    flush = 1'b1;
    @(posedge ck);
    #1;
    chk("flush_cnt", cnt4, 0);
    chk("flush_ev", ev4, 0);
    chk("flush_rdy", rdy4, 1);
    @(negedge ck) flush = 1'b0;

    // randomized run at DEPTH=3 against an in-order queue model
    sel3 = 1'b1;
    do_reset();
    begin
      int emit_m, emit_d;
      emit_m = 0;
      emit_d = 0;
      for (int t = 0; t < 200; t++) begin
        logic       iv, acc, cv, kill, er, leave, enq, found;
        logic       exp_ev;
        logic [3:0] iid, cid;
        int         newst, pick;
        @(negedge ck);
        iv   = ($urandom % 4) != 0;
        acc  = ($urandom % 8) != 0;
        cv   = ($urandom % 2) != 0;
        kill = ($urandom % 4) == 0;
        er   = ($urandom % 4) != 0;
        iid  = 4'($urandom);
        for (int g = 0; g < 64; g++) begin
          found = 1'b0;
          foreach (mq[k]) if (mq[k].id == iid) found = 1'b1;
          if (!found) break;
          iid = 4'($urandom);
        end
        pick = $urandom % 4;
        if (pick < 2 && mq.size() > 0)
          cid = mq[$urandom % mq.size()].id;
        else if (pick == 2)
          cid = iid;
        else
          cid = 4'($urandom);
        drive(iv, acc, iid, cv, cid, kill, er);
        #1;
        exp_ev = mq.size() > 0 && mq[0].st == 1;
        chk($sformatf("r%0d_ev", t), ev3, exp_ev);
        chk($sformatf("r%0d_cnt", t), cnt3, mq.size());
        chk($sformatf("r%0d_rdy", t), rdy3, mq.size() < 3);
        if (exp_ev) begin
          chk($sformatf("r%0d_id", t), id3, mq[0].id);
          chk($sformatf("r%0d_rs", t), rs3, mk_rs(mq[0].id));
        end
        if (ev3 && er) emit_d++;
        leave = mq.size() > 0 &&
                ((mq[0].st == 1 && er) || mq[0].st == 2);
        enq   = iv && acc && mq.size() < 3;
        found = 1'b0;
        if (cv) begin
          foreach (mq[k]) begin
            if (mq[k].id == cid && mq[k].st == 0) begin
              mq[k].st = kill ? 2 : 1;
              found = 1'b1;
            end
          end
        end
        newst = 0;
        if (cv && !found && enq && cid == iid) newst = kill ? 2 : 1;
        if (leave) begin
          if (mq[0].st == 1) emit_m++;
          void'(mq.pop_front());
        end
        if (enq) begin
          m_t e;
          e.id = iid;
          e.st = newst;
          mq.push_back(e);
        end
      end
      @(negedge ck) drive(0, 0, 0, 0, 0, 0, 0);
      chk("rand_emits", emit_d, emit_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
